// File: rtl/ram_arbiter.sv
// Two-client round-robin arbiter and sequencer in front of a single-port synchronous RAM.
// Define RAM_ARB_SCRUB_EN to zero the whole RAM after reset before accepting requests.
module ram_arbiter #(
  parameter int AWID   = 8,
  parameter int DWID   = 16,
  parameter int RD_LAT = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_a_req,
  input  logic            i_a_we,
  input  logic [AWID-1:0] i_a_addr,
  input  logic [DWID-1:0] i_a_dat,
  output logic            o_a_gnt,
  output logic            o_a_rvalid,
  output logic [DWID-1:0] o_a_rdat,
  input  logic            i_b_req,
  input  logic            i_b_we,
  input  logic [AWID-1:0] i_b_addr,
  input  logic [DWID-1:0] i_b_dat,
  output logic            o_b_gnt,
  output logic            o_b_rvalid,
  output logic [DWID-1:0] o_b_rdat,
  output logic            o_ram_we,
  output logic [AWID-1:0] o_ram_addr,
  output logic [DWID-1:0] o_ram_dat,
  input  logic [DWID-1:0] i_ram_dat,
  output logic            o_busy
);

`ifdef RAM_ARB_SCRUB_EN
  typedef enum logic {ST_INIT, ST_ARB} state_t;
`else
  typedef enum logic {ST_ARB} state_t;
`endif
  typedef enum logic {SIDE_A, SIDE_B} side_t;

  state_t          state_q, state_d;
  side_t           last_grant_q;
  logic            gnt_a, gnt_b;
  logic            push_vld;
  logic [RD_LAT:0] tag_vld_q;
  logic [RD_LAT:0] tag_side_q;
`ifdef RAM_ARB_SCRUB_EN
  logic [AWID-1:0] scrub_addr_q;
`endif

  // Grants are masked while reset is asserted so no command is seen as accepted.
  always_comb begin
    state_d = state_q;
    gnt_a   = 1'b0;
    gnt_b   = 1'b0;
    case (state_q)
`ifdef RAM_ARB_SCRUB_EN
      ST_INIT: begin
        if (scrub_addr_q == '1) state_d = ST_ARB;
      end
`endif
      ST_ARB: begin
        if (rst_n) begin
          if (i_a_req && i_b_req) begin
            if (last_grant_q == SIDE_B) gnt_a = 1'b1;
            else                        gnt_b = 1'b1;
          end else begin
            gnt_a = i_a_req;
            gnt_b = i_b_req;
          end
        end
      end
      default: state_d = ST_ARB;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
`ifdef RAM_ARB_SCRUB_EN
      state_q <= ST_INIT;
`else
      state_q <= ST_ARB;
`endif
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_ram_we     <= 1'b0;
      o_ram_addr   <= '0;
      o_ram_dat    <= '0;
      last_grant_q <= SIDE_B;
    end else begin
      o_ram_we <= 1'b0;
`ifdef RAM_ARB_SCRUB_EN
      if (state_q == ST_INIT) begin
        o_ram_we   <= 1'b1;
        o_ram_addr <= scrub_addr_q;
        o_ram_dat  <= '0;
      end else
`endif
      if (gnt_a) begin
        o_ram_we     <= i_a_we;
        o_ram_addr   <= i_a_addr;
        o_ram_dat    <= i_a_dat;
        last_grant_q <= SIDE_A;
      end else if (gnt_b) begin
        o_ram_we     <= i_b_we;
        o_ram_addr   <= i_b_addr;
        o_ram_dat    <= i_b_dat;
        last_grant_q <= SIDE_B;
      end
    end
  end

`ifdef RAM_ARB_SCRUB_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 scrub_addr_q <= '0;
    else if (state_q == ST_INIT) scrub_addr_q <= scrub_addr_q + 1'b1;
  end
`endif

  // Tag stage k holds the read granted k+1 cycles ago; stage RD_LAT lines up with i_ram_dat.
  assign push_vld = (gnt_a & ~i_a_we) | (gnt_b & ~i_b_we);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_vld_q  <= '0;
      tag_side_q <= '0;
    end else begin
      tag_vld_q  <= {tag_vld_q[RD_LAT-1:0], push_vld};
      tag_side_q <= {tag_side_q[RD_LAT-1:0], gnt_b};
    end
  end

  assign o_a_gnt    = gnt_a;
  assign o_b_gnt    = gnt_b;
  assign o_a_rvalid = tag_vld_q[RD_LAT] & ~tag_side_q[RD_LAT];
  assign o_b_rvalid = tag_vld_q[RD_LAT] &  tag_side_q[RD_LAT];
  assign o_a_rdat   = i_ram_dat;
  assign o_b_rdat   = i_ram_dat;

`ifdef RAM_ARB_SCRUB_EN
  assign o_busy = (state_q == ST_INIT);
`else
  assign o_busy = 1'b0;
`endif

endmodule

// File: tb/tb_ram_arbiter.sv
// Self-checking bench for ram_arbiter: behavioural RAM fixture plus a transaction-level
// reference model (grant rule, memory array, queue of expected read returns).
`timescale 1ns/1ps
module tb_ram_arbiter #(
  parameter int RD_LAT = 1
);
  localparam int AWID = 8;
  localparam int DWID = 16;
  localparam int DEPTH = 1 << AWID;
  localparam int W = 6 + AWID + 2 * DWID;
`ifdef RAM_ARB_SCRUB_EN
  localparam bit SCRUB = 1'b1;
`else
  localparam bit SCRUB = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic            a_req, a_we, b_req, b_we;
  logic [AWID-1:0] a_addr, b_addr;
  logic [DWID-1:0] a_dat, b_dat;
  logic            a_gnt, a_rvalid, b_gnt, b_rvalid;
  logic [DWID-1:0] a_rdat, b_rdat;
  logic            ram_we, busy;
  logic [AWID-1:0] ram_addr;
  logic [DWID-1:0] ram_wdat, ram_rdat;

  ram_arbiter #(.AWID(AWID), .DWID(DWID), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_a_req(a_req), .i_a_we(a_we), .i_a_addr(a_addr), .i_a_dat(a_dat),
    .o_a_gnt(a_gnt), .o_a_rvalid(a_rvalid), .o_a_rdat(a_rdat),
    .i_b_req(b_req), .i_b_we(b_we), .i_b_addr(b_addr), .i_b_dat(b_dat),
    .o_b_gnt(b_gnt), .o_b_rvalid(b_rvalid), .o_b_rdat(b_rdat),
    .o_ram_we(ram_we), .o_ram_addr(ram_addr), .o_ram_dat(ram_wdat),
    .i_ram_dat(ram_rdat), .o_busy(busy)
  );

  // Single-port synchronous RAM with RD_LAT cycles of read latency.
  logic            fill_ffff = 1'b0;
  logic [DWID-1:0] mem [DEPTH];
  logic [DWID-1:0] rd_pipe [RD_LAT];
  always @(posedge clk) begin
    if (fill_ffff) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '1;
    end else if (ram_we) begin
      mem[ram_addr] <= ram_wdat;
    end
    rd_pipe[0] <= mem[ram_addr];
    for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign ram_rdat = rd_pipe[RD_LAT-1];

  typedef struct {
    int              cyc;
    logic            side;
    logic [DWID-1:0] dat;
  } rd_t;

  rd_t             exp_q[$];
  logic [DWID-1:0] ref_mem [DEPTH];
  int              cyc, scyc;
  logic            last_b;
  logic            m_we;
  logic [AWID-1:0] m_addr;
  logic [DWID-1:0] m_dat;
  logic [W-1:0]    obs_all, exp_all;
  logic            s_ga, s_gb, s_rva, s_rvb, s_busy;
  logic [DWID-1:0] s_ardat, s_brdat;
  int              n_checks, n_fails;

  task automatic model_reset();
    exp_q.delete();
    cyc    = 0;
    last_b = 1'b1;
    m_we   = 1'b0;
    m_addr = '0;
    m_dat  = '0;
  endtask

  // Drives one cycle, samples the DUT at the falling edge and advances the reference model.
  task automatic run_cycle(input logic ar, input logic aw, input logic [AWID-1:0] aa,
                           input logic [DWID-1:0] ad, input logic br, input logic bw,
                           input logic [AWID-1:0] ba, input logic [DWID-1:0] bd);
    rd_t r;
    logic bsy, ga, gb, rva, rvb, gwe;
    logic [AWID-1:0] gaddr;
    logic [DWID-1:0] gdat, erd, ord;
    a_req = ar; a_we = aw; a_addr = aa; a_dat = ad;
    b_req = br; b_we = bw; b_addr = ba; b_dat = bd;
    @(negedge clk);
    bsy = SCRUB && (cyc < DEPTH);
    ga = 1'b0;
    gb = 1'b0;
    if (!bsy) begin
      if (ar && br) begin
        ga = last_b;
        gb = !last_b;
      end else begin
        ga = ar;
        gb = br;
      end
    end
    rva = 1'b0;
    rvb = 1'b0;
    erd = '0;
    if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
      r   = exp_q.pop_front();
      rva = !r.side;
      rvb = r.side;
      erd = r.dat;
    end
    ord = rva ? a_rdat : (rvb ? b_rdat : '0);
    exp_all = {ga, gb, rva, rvb, m_we, bsy, m_addr, m_dat, erd};
    obs_all = {a_gnt, b_gnt, a_rvalid, b_rvalid, ram_we, busy, ram_addr, ram_wdat, ord};
    s_ga = a_gnt; s_gb = b_gnt; s_rva = a_rvalid; s_rvb = b_rvalid; s_busy = busy;
    s_ardat = a_rdat; s_brdat = b_rdat;
    scyc = cyc;
    m_we = 1'b0;
    if (bsy) begin
      ref_mem[cyc] = '0;
      m_we   = 1'b1;
      m_addr = AWID'(cyc);
      m_dat  = '0;
    end else if (ga || gb) begin
      gwe    = ga ? aw : bw;
      gaddr  = ga ? aa : ba;
      gdat   = ga ? ad : bd;
      last_b = gb;
      m_we   = gwe;
      m_addr = gaddr;
      m_dat  = gdat;
      if (gwe) begin
        ref_mem[gaddr] = gdat;
      end else begin
        r.cyc  = cyc + 1 + RD_LAT;
        r.side = gb;
        r.dat  = ref_mem[gaddr];
        exp_q.push_back(r);
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle_cycle();
    run_cycle(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic test_reset();
    a_req = 1'b1; a_we = 1'b0; a_addr = AWID'(1); a_dat = '0;
    b_req = 1'b1; b_we = 1'b1; b_addr = AWID'(2); b_dat = '1;
    rst_n = 1'b0;
    fill_ffff = 1'b1;
    repeat (3) @(posedge clk);
    #1 fill_ffff = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({a_gnt, b_gnt, a_rvalid, b_rvalid, ram_we, busy} !== {5'b0, SCRUB}
        || ram_addr !== '0 || ram_wdat !== '0) begin
      n_fails++;
      $display("FAIL reset_state got gnt=%b%b rv=%b%b we=%b busy=%b addr=%h dat=%h want all 0 busy=%b",
               a_gnt, b_gnt, a_rvalid, b_rvalid, ram_we, busy, ram_addr, ram_wdat, SCRUB);
    end
    a_req = 1'b0;
    b_req = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    model_reset();
  endtask

  task automatic wait_ready();
    for (int i = 0; i < DEPTH + 2 && busy === 1'b1; i++) begin
      idle_cycle();
      n_checks++;
      if (obs_all !== exp_all) begin
        n_fails++;
        $display("FAIL ready_wait cyc=%0d got=%h want=%h", scyc, obs_all, exp_all);
      end
    end
  endtask

`ifdef RAM_ARB_SCRUB_EN
  task automatic test_scrub();
    int busy_n = 0;
    int g = -1;
    logic seen = 1'b0;
    logic [DWID-1:0] d = 'x;
    for (int i = 0; i < DEPTH + 8 && g < 0; i++) begin
      run_cycle(1'b1, 1'b0, AWID'(200), 16'h1234, 1'b0, 1'b0, '0, '0);
      n_checks++;
      if (obs_all !== exp_all) begin
        n_fails++;
        $display("FAIL scrub cyc=%0d got=%h want=%h", scyc, obs_all, exp_all);
      end
      if (s_busy) busy_n++;
      if (s_ga) g = scyc;
    end
    n_checks++;
    if (busy_n != DEPTH) begin
      n_fails++;
      $display("FAIL scrub_busy_len got=%0d want=%0d", busy_n, DEPTH);
    end
    n_checks++;
    if (g != DEPTH) begin
      n_fails++;
      $display("FAIL scrub_held_gnt got cycle %0d want %0d", g, DEPTH);
    end
    for (int i = 0; i < RD_LAT + 2; i++) begin
      idle_cycle();
      n_checks++;
      if (obs_all !== exp_all) begin
        n_fails++;
        $display("FAIL scrub_read cyc=%0d got=%h want=%h", scyc, obs_all, exp_all);
      end
      if (s_rva) begin
        seen = 1'b1;
        d = s_ardat;
      end
    end
    n_checks++;
    if (!seen || d !== 16'h0000) begin
      n_fails++;
      $display("FAIL scrub_addr200 got rvalid=%b dat=%h want rvalid=1 dat=0000", seen, d);
    end
  endtask
`endif

  task automatic test_fill();
    int miss = 0;
    int nrv = 0;
    int brv = 0;
    int g;
    int gq[$];
    for (int k = 0; k < DEPTH; k++) begin
      run_cycle(1'b1, 1'b1, AWID'(k), DWID'(k + 'h100), 1'b0, 1'b0, '0, '0);
      n_checks++;
      if (obs_all !== exp_all) begin
        n_fails++;
        $display("FAIL fill cyc=%0d got=%h want=%h", scyc, obs_all, exp_all);
      end
      if (!s_ga) miss++;
    end
    n_checks++;
    if (miss != 0) begin
      n_fails++;
      $display("FAIL fill_gnt_every_cycle got %0d missing grants want 0", miss);
    end
    for (int i = 0; i < 4 + RD_LAT + 2; i++) begin
      if (i < 4) run_cycle(1'b1, 1'b0, AWID'(5 + i), '0, 1'b0, 1'b0, '0, '0);
      else       idle_cycle();
      n_checks++;
      if (obs_all !== exp_all) begin
        n_fails++;
        $display("FAIL read_seq cyc=%0d got=%h want=%h", scyc, obs_all, exp_all);
      end
      if (s_ga) gq.push_back(scyc);
      if (s_rvb) brv++;
      if (s_rva) begin
        g = (gq.size() > 0) ? gq.pop_front() : -100;
        n_checks++;
        if (scyc - g != RD_LAT + 1 || s_ardat !== DWID'(16'h105 + nrv)) begin
          n_fails++;
          $display("FAIL read_latency got lat=%0d dat=%h want lat=%0d dat=%h",
                   scyc - g, s_ardat, RD_LAT + 1, DWID'(16'h105 + nrv));
        end
        nrv++;
      end
    end
    n_checks++;
    if (nrv != 4 || brv != 0) begin
      n_fails++;
      $display("FAIL read_count got a=%0d b=%0d want a=4 b=0", nrv, brv);
    end
  endtask

  task automatic test_alternate();
    logic [7:0] gpat = '0;
    int nrv = 0;
    int bad = 0;
    logic want_b;
    logic [DWID-1:0] want_d, got_d;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    model_reset();
    wait_ready();
    for (int i = 0; i < 2 + 8 + RD_LAT + 2; i++) begin
      if (i == 0)      run_cycle(1'b1, 1'b1, AWID'(3), 16'h0103, 1'b0, 1'b0, '0, '0);
      else if (i == 1) run_cycle(1'b0, 1'b0, '0, '0, 1'b1, 1'b1, AWID'(7), 16'h0107);
      else if (i < 10) run_cycle(1'b1, 1'b0, AWID'(3), '0, 1'b1, 1'b0, AWID'(7), '0);
      else             idle_cycle();
      n_checks++;
      if (obs_all !== exp_all) begin
        n_fails++;
        $display("FAIL alternate cyc=%0d got=%h want=%h", scyc, obs_all, exp_all);
      end
      if (i >= 2 && i < 10) begin
        gpat = {gpat[6:0], s_ga};
        if (s_ga == s_gb) bad++;
      end
      if (s_rva || s_rvb) begin
        want_b = (nrv % 2) == 1;
        want_d = want_b ? 16'h0107 : 16'h0103;
        got_d  = s_rvb ? s_brdat : s_ardat;
        n_checks++;
        if (s_rvb !== want_b || s_rva !== !want_b || got_d !== want_d) begin
          n_fails++;
          $display("FAIL alternate_rvalid #%0d got a=%b b=%b dat=%h want b=%b dat=%h",
                   nrv, s_rva, s_rvb, got_d, want_b, want_d);
        end
        nrv++;
      end
    end
    n_checks++;
    if (gpat !== 8'b10101010 || bad != 0) begin
      n_fails++;
      $display("FAIL alternate_gnt got pattern=%b onehot_errs=%0d want 10101010 0", gpat, bad);
    end
    n_checks++;
    if (nrv != 8) begin
      n_fails++;
      $display("FAIL alternate_count got %0d want 8", nrv);
    end
  endtask

  task automatic test_raw();
    int n;
    int at = -1;
    logic [DWID-1:0] d = 'x;
    run_cycle(1'b1, 1'b1, AWID'(9), 16'hBEEF, 1'b0, 1'b0, '0, '0);
    n = scyc;
    n_checks++;
    if (obs_all !== exp_all || !s_ga) begin
      n_fails++;
      $display("FAIL raw_write got=%h want=%h", obs_all, exp_all);
    end
    for (int i = 0; i < RD_LAT + 3; i++) begin
      if (i == 0) run_cycle(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, AWID'(9), '0);
      else        idle_cycle();
      n_checks++;
      if (obs_all !== exp_all) begin
        n_fails++;
        $display("FAIL raw cyc=%0d got=%h want=%h", scyc, obs_all, exp_all);
      end
      if (s_rvb) begin
        at = scyc;
        d  = s_brdat;
      end
    end
    n_checks++;
    if (at != n + 2 + RD_LAT || d !== 16'hBEEF) begin
      n_fails++;
      $display("FAIL raw_read got cycle=%0d dat=%h want cycle=%0d dat=beef", at, d, n + 2 + RD_LAT);
    end
  endtask

  task automatic test_reset_inflight();
    int stray = 0;
    for (int i = 0; i < 2; i++) begin
      run_cycle(1'b1, 1'b0, AWID'(3 + 4 * i), '0, 1'b0, 1'b0, '0, '0);
      n_checks++;
      if (obs_all !== exp_all) begin
        n_fails++;
        $display("FAIL inflight_issue cyc=%0d got=%h want=%h", scyc, obs_all, exp_all);
      end
    end
    a_req = 1'b0;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({a_rvalid, b_rvalid, ram_we, a_gnt, b_gnt} !== 5'b0 || ram_addr !== '0) begin
      n_fails++;
      $display("FAIL async_reset got rv=%b%b we=%b gnt=%b%b addr=%h want all 0",
               a_rvalid, b_rvalid, ram_we, a_gnt, b_gnt, ram_addr);
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    model_reset();
    wait_ready();
    for (int i = 0; i < RD_LAT + 3; i++) begin
      idle_cycle();
      n_checks++;
      if (obs_all !== exp_all) begin
        n_fails++;
        $display("FAIL inflight_drop cyc=%0d got=%h want=%h", scyc, obs_all, exp_all);
      end
      if (s_rva || s_rvb) stray++;
    end
    n_checks++;
    if (stray != 0) begin
      n_fails++;
      $display("FAIL inflight_no_rvalid got %0d pulses want 0", stray);
    end
    run_cycle(1'b1, 1'b0, AWID'(3), '0, 1'b1, 1'b0, AWID'(7), '0);
    n_checks++;
    if (!s_ga || s_gb || obs_all !== exp_all) begin
      n_fails++;
      $display("FAIL first_tie got gnt a=%b b=%b all=%h want a=1 b=0 all=%h", s_ga, s_gb, obs_all, exp_all);
    end
    for (int i = 0; i < RD_LAT + 2; i++) begin
      idle_cycle();
      n_checks++;
      if (obs_all !== exp_all) begin
        n_fails++;
        $display("FAIL inflight_drain cyc=%0d got=%h want=%h", scyc, obs_all, exp_all);
      end
    end
  endtask

  task automatic test_random();
    logic pa = 1'b0, pb = 1'b0, aw = 1'b0, bw = 1'b0;
    logic [AWID-1:0] aa = '0, ba = '0;
    logic [DWID-1:0] ad = '0, bd = '0;
    for (int i = 0; i < 400 + RD_LAT + 2; i++) begin
      if (i < 400) begin
        if (!pa) begin
          pa = $urandom_range(0, 9) < 7;
          aw = 1'($urandom_range(0, 1));
          aa = AWID'($urandom_range(0, 15));
          ad = DWID'($urandom);
        end
        if (!pb) begin
          pb = $urandom_range(0, 9) < 7;
          bw = 1'($urandom_range(0, 1));
          ba = AWID'($urandom_range(0, 15));
          bd = DWID'($urandom);
        end
      end else begin
        pa = 1'b0;
        pb = 1'b0;
      end
      run_cycle(pa, aw, aa, ad, pb, bw, ba, bd);
      n_checks++;
      if (obs_all !== exp_all) begin
        n_fails++;
        $display("FAIL random cyc=%0d got=%h want=%h", scyc, obs_all, exp_all);
      end
      if (s_ga) pa = 1'b0;
      if (s_gb) pb = 1'b0;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout simulation did not complete");
    $fatal(1);
  end

  initial begin
    n_checks = 0;
    n_fails  = 0;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '1;
    model_reset();
    test_reset();
`ifdef RAM_ARB_SCRUB_EN
    test_scrub();
`endif
    test_fill();
    test_alternate();
    test_raw();
    test_reset_inflight();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
